// File: rtl/periph_apb_bridge_pkg.sv
// Shared types and constants for the core-bus to APB3 bridge.
// Holds the FSM state encoding, the timeout read-data pattern and the response record.
package periph_apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } bridge_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // The response ID field is sized for the widest supported ID; the top zero-extends into it.
  localparam int RESP_ID_W = 8;

  typedef struct packed {
    logic [31:0]          rdata;
    logic                 opc;
    logic [RESP_ID_W-1:0] id;
  } bridge_resp_t;

  function automatic bridge_resp_t make_resp(input logic [31:0]          rdata,
                                             input logic                 opc,
                                             input logic [RESP_ID_W-1:0] id);
    bridge_resp_t r;
    r.rdata = rdata;
    r.opc   = opc;
    r.id    = id;
    return r;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the last permitted wait cycle.
// TIMEOUT_CYCLES = 0 removes the counter and keeps expired low forever.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, srst, clear, enable};
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] wait_cnt_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          wait_cnt_reg <= '0;
        end else if (clear) begin
          wait_cnt_reg <= '0;
        end else if (enable && !expired) begin
          wait_cnt_reg <= wait_cnt_reg + CW'(1);
        end
      end

      assign expired = (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/periph_to_apb_bridge.sv
// Core-side req/gnt + r_valid peripheral bus to APB3 master, one transaction at a time.
// The response is registered and strobes for one cycle after the completing edge.
module periph_to_apb_bridge
  import periph_apb_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int ID_WIDTH       = 2,   // at most RESP_ID_W
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic [31:0]               add_i,
  input  logic                      wen_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                be_i,
  input  logic [ID_WIDTH-1:0]       id_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [31:0]               r_rdata_o,
  output logic                      r_opc_o,
  output logic [ID_WIDTH-1:0]       r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  bridge_state_e             state_reg, state_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic                      pwrite_reg;
  logic [31:0]               pwdata_reg;
  logic [ID_WIDTH-1:0]       id_reg;
  bridge_resp_t              resp_reg, resp_next;
  logic                      r_valid_reg, r_valid_next;
  logic                      accept;
  logic                      timer_enable;
  logic                      timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (HCLK),
    .srst   (HRESET),
    .clear  (accept),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    timer_enable = 1'b0;
    r_valid_next = 1'b0;
    resp_next    = resp_reg;
    case (state_reg)
      IDLE: begin
        if (req_i) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        // PREADY has priority over an expiring wait counter in the same cycle.
        if (PREADY) begin
          state_next   = IDLE;
          r_valid_next = 1'b1;
          resp_next    = make_resp(pwrite_reg ? 32'h0 : PRDATA, PSLVERR, RESP_ID_W'(id_reg));
        end else if (timer_expired) begin
          state_next   = IDLE;
          r_valid_next = 1'b1;
          resp_next    = make_resp(ERR_RDATA, 1'b1, RESP_ID_W'(id_reg));
        end else begin
          timer_enable = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg   <= IDLE;
      paddr_reg   <= '0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= '0;
      id_reg      <= '0;
      resp_reg    <= '0;
      r_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      resp_reg    <= resp_next;
      r_valid_reg <= r_valid_next;
      if (accept) begin
        paddr_reg  <= add_i[APB_ADDR_WIDTH-1:0];
        pwrite_reg <= ~wen_i;
        pwdata_reg <= wdata_i;
        id_reg     <= id_i;
      end
    end
  end

  // The grant is masked during reset so a request is never accepted into a resetting FSM.
  assign gnt_o     = (state_reg == IDLE) && req_i && !HRESET;
  assign PSEL      = (state_reg != IDLE);
  assign PENABLE   = (state_reg == ACCESS);
  assign PADDR     = paddr_reg;
  assign PWRITE    = pwrite_reg;
  assign PWDATA    = pwdata_reg;
  assign r_valid_o = r_valid_reg;
  assign r_rdata_o = resp_reg.rdata;
  assign r_opc_o   = resp_reg.opc;
  assign r_id_o    = resp_reg.id[ID_WIDTH-1:0];

  logic unused_inputs;
  assign unused_inputs = ^{be_i, add_i[31:APB_ADDR_WIDTH], resp_reg.id[RESP_ID_W-1:ID_WIDTH]};

endmodule

// File: tb/tb_periph_to_apb_bridge.sv
// Self-checking bench for periph_to_apb_bridge: directed cases plus randomized transactions
// compared against a transaction-level response/latency model.
module tb_periph_to_apb_bridge;

  localparam int TIMEOUT = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_i;
  logic [31:0] add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [1:0]  id_i;
  logic        gnt_o, r_valid_o, r_opc_o;
  logic [31:0] r_rdata_o;
  logic [1:0]  r_id_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic        prdata_auto;
  logic [31:0] prdata_drv;

  int tests  = 0;
  int failed = 0;

  always #5 HCLK = ~HCLK;

  assign PRDATA = prdata_auto ? {20'hB0000, PADDR} : prdata_drv;

  periph_to_apb_bridge #(
    .APB_ADDR_WIDTH(12),
    .ID_WIDTH      (2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .req_i    (req_i),
    .add_i    (add_i),
    .wen_i    (wen_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .id_i     (id_i),
    .gnt_o    (gnt_o),
    .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o),
    .r_opc_o  (r_opc_o),
    .r_id_o   (r_id_o),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: what the initiator must see for a given slave behaviour.
  function automatic logic [32:0] exp_resp(input logic rd, input logic slverr,
                                           input logic timed_out, input logic [31:0] prd);
    if (timed_out) return {1'b1, 32'hDEAD_BEEF};
    if (!rd)       return {slverr, 32'h0};
    return {slverr, prd};
  endfunction

  // Called at a negedge with the bridge idle; returns at a negedge with the bridge idle.
  // waits >= TIMEOUT means the slave never raises PREADY.
  task automatic do_txn(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                        input logic [1:0] id, input int waits, input logic slverr,
                        input logic [31:0] rdata_val);
    int          cyc;
    int          acc;
    int          exp_lat;
    logic        stable;
    logic        timed_out;
    logic [32:0] exp;
    timed_out = (waits >= TIMEOUT);
    exp       = exp_resp(rd, slverr, timed_out, rdata_val);
    exp_lat   = timed_out ? TIMEOUT + 2 : waits + 3;

    req_i = 1'b1; add_i = addr; wen_i = rd; wdata_i = wdata; id_i = id; be_i = 4'($urandom);
    #1 check("gnt", 64'(gnt_o), 64'd1);
    @(negedge HCLK);
    req_i = 1'b0; add_i = $urandom; wdata_i = $urandom; id_i = 2'($urandom); wen_i = 1'($urandom);
    cyc = 1;
    check("setup_psel_penable", 64'({PSEL, PENABLE}), 64'b10);
    check("setup_gnt_low", 64'(gnt_o), 64'd0);
    check("paddr", 64'(PADDR), 64'(addr[11:0]));
    check("pwrite", 64'(PWRITE), 64'(!rd));
    check("pwdata", 64'(PWDATA), 64'(wdata));
    @(negedge HCLK);
    cyc = 2; acc = 0; stable = 1'b1;
    while (PSEL === 1'b1 && cyc < 100) begin
      if (PENABLE !== 1'b1 || PADDR !== addr[11:0] || PWRITE !== !rd || PWDATA !== wdata)
        stable = 1'b0;
      PREADY     = (acc == waits);
      PSLVERR    = (acc == waits) ? slverr : 1'($urandom);
      prdata_drv = (acc == waits) ? rdata_val : $urandom;
      @(negedge HCLK);
      cyc++; acc++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    check("access_stable", 64'(stable), 64'd1);
    check("psel_drop", 64'(PSEL), 64'd0);
    check("latency", 64'(cyc), 64'(exp_lat));
    check("r_valid", 64'(r_valid_o), 64'd1);
    check("resp_opc_rdata", 64'({r_opc_o, r_rdata_o}), 64'(exp));
    check("r_id", 64'(r_id_o), 64'(id));
    $display("[TB] txn %s addr=%08h id=%0d waits=%0d slverr=%0d -> opc=%0d rdata=%08h lat=%0d",
             rd ? "RD" : "WR", addr, id, waits, slverr, r_opc_o, r_rdata_o, cyc);
    @(negedge HCLK);
    check("r_valid_pulse", 64'(r_valid_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  ids[4];
    logic [31:0] addrs[4];
    int          ng;
    int          nr;

    HRESET = 1'b1; req_i = 1'b1; add_i = 32'h0; wen_i = 1'b0; wdata_i = 32'h0; be_i = 4'h0;
    id_i = 2'b0; PREADY = 1'b0; PSLVERR = 1'b0; prdata_auto = 1'b0; prdata_drv = 32'h0;
    repeat (3) @(negedge HCLK);
    #1 check("gnt_in_reset", 64'(gnt_o), 64'd0);
    req_i = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    check("reset_apb", 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'd0);
    check("reset_pwdata", 64'(PWDATA), 64'd0);
    check("reset_resp", 64'({r_valid_o, r_opc_o, r_id_o, r_rdata_o}), 64'd0);
    @(negedge HCLK);

    // Directed cases
    do_txn(32'h0000_1A2C, 1'b1, 32'h1234_5678, 2'b01, 0, 1'b0, 32'hCAFE_0001);
    do_txn(32'h0000_0040, 1'b0, 32'h0000_00FF, 2'b10, 4, 1'b0, 32'h5555_AAAA);
    do_txn(32'h0000_0F00, 1'b1, 32'h0,         2'b11, TIMEOUT, 1'b0, 32'h0);
    do_txn(32'h0000_0124, 1'b1, 32'h0,         2'b00, 0, 1'b0, 32'h0BAD_F00D);
    do_txn(32'h0000_0ABC, 1'b1, 32'h0,         2'b01, 2, 1'b1, 32'h7777_1234);
    do_txn(32'h0000_0333, 1'b1, 32'h0,         2'b10, TIMEOUT - 1, 1'b0, 32'h1111_2222);
    do_txn(32'h0000_0444, 1'b0, 32'hFFFF_0000, 2'b11, 1, 1'b1, 32'h0);

    // Back-to-back: continuous req_i for 4 reads with an always-ready slave
    ids   = '{2'd3, 2'd0, 2'd2, 2'd1};
    addrs = '{32'h0000_0010, 32'h0000_0824, 32'h0000_0FFC, 32'h0000_5100};
    prdata_auto = 1'b1; PREADY = 1'b1;
    ng = 0; nr = 0;
    req_i = 1'b1; wen_i = 1'b1; add_i = addrs[0]; id_i = ids[0];
    for (int t = 0; t < 16; t++) begin
      #1;
      if (r_valid_o) begin
        if (nr < 4) begin
          check("b2b_rv_cycle", 64'(t), 64'(3 * nr + 3));
          check("b2b_r_id", 64'(r_id_o), 64'(ids[nr]));
          check("b2b_rdata", 64'({r_opc_o, r_rdata_o}), 64'({1'b0, 20'hB0000, addrs[nr][11:0]}));
          $display("[TB] b2b rsp %0d id=%0d rdata=%08h cycle=%0d", nr, r_id_o, r_rdata_o, t);
        end else begin
          check("b2b_extra_rvalid", 64'(r_valid_o), 64'd0);
        end
        nr++;
      end
      if (gnt_o) begin
        check("b2b_gnt_cycle", 64'(t), 64'(3 * ng));
        ng++;
      end
      @(negedge HCLK);
      if (ng < 4) begin
        add_i = addrs[ng]; id_i = ids[ng];
      end else begin
        req_i = 1'b0;
      end
    end
    check("b2b_grants", 64'(ng), 64'd4);
    check("b2b_responses", 64'(nr), 64'd4);
    PREADY = 1'b0; prdata_auto = 1'b0;

    // Reset asserted while the bridge waits in ACCESS
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0000_0777; id_i = 2'b10;
    @(negedge HCLK);
    req_i = 1'b0;
    @(negedge HCLK);
    check("rst_in_access", 64'({PSEL, PENABLE}), 64'b11);
    @(negedge HCLK);
    HRESET = 1'b1; req_i = 1'b1;
    @(negedge HCLK);
    #1;
    check("rst_apb_low", 64'({PSEL, PENABLE, r_valid_o}), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_gnt_masked", 64'(gnt_o), 64'd0);
    HRESET = 1'b0; req_i = 1'b0;
    @(negedge HCLK);
    check("rst_no_resp_1", 64'({r_valid_o, PSEL}), 64'd0);
    @(negedge HCLK);
    check("rst_no_resp_2", 64'({r_valid_o, PSEL}), 64'd0);
    $display("[TB] reset during ACCESS dropped the transaction");
    do_txn(32'h0000_0ACE, 1'b1, 32'h0, 2'b11, 1, 1'b0, 32'h600D_DA7A);

    // Randomized transactions
    for (int k = 0; k < 12; k++) begin
      do_txn($urandom, 1'($urandom), $urandom, 2'($urandom),
             int'($urandom_range(0, TIMEOUT + 1)), 1'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
